// File: rtl/vfpu_stream_engine_pkg.sv
// Shared types and lane arithmetic for the vector stream engine.
// The lane operation is a pure function so every lane and any model use identical semantics.
package vfpu_package;

    localparam int VFPU_LANE_WIDTH = 32;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        MIN = 3'd5,
        MAX = 3'd6
    } vfpu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vfpu_eng_state_t;

    // Reserved opcodes fall through to zero.
    function automatic logic [VFPU_LANE_WIDTH-1:0] vfpu_lane_op(
        input logic [VFPU_LANE_WIDTH-1:0] a,
        input logic [VFPU_LANE_WIDTH-1:0] b,
        input logic [2:0]                 op
    );
        logic [VFPU_LANE_WIDTH-1:0] r;
        r = '0;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            OR:      r = a | b;
            XOR:     r = a ^ b;
            MIN:     r = ($signed(a) < $signed(b)) ? a : b;
            MAX:     r = ($signed(a) > $signed(b)) ? a : b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vfpu_stream_engine_lane_alu.sv
// One 32-bit lane: operation registered in the first stage, then LATENCY-1 plain delay stages.
// Data stages carry no reset; validity is tracked by the engine's shift register.
module vfpu_lane_alu
    import vfpu_package::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                       clk_i,
    input  logic [VFPU_LANE_WIDTH-1:0] a,
    input  logic [VFPU_LANE_WIDTH-1:0] b,
    input  logic [2:0]                 op,
    output logic [VFPU_LANE_WIDTH-1:0] result
);

    logic [VFPU_LANE_WIDTH-1:0] stage_reg [LATENCY];

    always_ff @(posedge clk_i) begin
        stage_reg[0] <= vfpu_lane_op(a, b, op);
        for (int i = 1; i < LATENCY; i++) begin
            stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign result = stage_reg[LATENCY-1];

endmodule

// File: rtl/vfpu_stream_engine.sv
// Joins two operand streams, runs a fixed-latency per-lane op, buffers results in a FIFO
// and reports job completion after a programmed number of elements.
module vfpu_stream_engine
    import vfpu_package::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NB_OPERANDS = 2,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  logic [31:0]                       len_i,
    input  logic [2:0]                        op_i,
    input  logic [NB_OPERANDS-1:0]            operand_valid,
    output logic [NB_OPERANDS-1:0]            operand_ready,
    input  logic [NB_OPERANDS*DATA_WIDTH-1:0] operand_data,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [DATA_WIDTH-1:0]             result_data,
    output logic [DATA_WIDTH/8-1:0]           result_strb,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [31:0]                       cnt_o
);

    localparam int NB_LANES = DATA_WIDTH / VFPU_LANE_WIDTH;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    vfpu_eng_state_t state_reg, state_next;
    logic            done_reg, done_next;
    logic            busy;

    logic [31:0]     len_reg;
    logic [31:0]     issue_cnt_reg;
    logic [31:0]     out_cnt_reg;
    logic [2:0]      op_reg;

    logic [LATENCY-1:0]    valid_reg;
    logic [DATA_WIDTH-1:0] pipe_data;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      fifo_cnt_reg;

    logic soft_rst;
    logic acc;
    logic push;
    logic pop;
    logic start_job;
    int   inflight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign soft_rst = !rst_ni || clear_i;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + 32'(valid_reg[i]);
        end
    end

    // Credit check counts in-flight elements so a pipeline that never stalls cannot overflow the FIFO.
    assign acc = (state_reg == RUN) && (&operand_valid) && !soft_rst &&
                 ((inflight + int'(fifo_cnt_reg)) < FIFO_DEPTH);

    assign operand_ready = {NB_OPERANDS{acc}};
    assign push          = valid_reg[LATENCY-1];
    assign result_valid  = (fifo_cnt_reg != '0);
    assign pop           = result_valid && result_ready;
    assign result_data   = fifo_mem[rd_ptr_reg];
    assign result_strb   = '1;
    assign start_job     = (state_reg == IDLE) && start_i;

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    if (len_i != 32'd0) state_next = RUN;
                    else                done_next  = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (acc && (issue_cnt_reg + 32'd1 == len_reg)) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && (out_cnt_reg + 32'd1 == len_reg)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            len_reg       <= '0;
            op_reg        <= '0;
            issue_cnt_reg <= '0;
            out_cnt_reg   <= '0;
        end else if (start_job) begin
            len_reg       <= len_i;
            op_reg        <= op_i;
            issue_cnt_reg <= '0;
            out_cnt_reg   <= '0;
        end else begin
            if (acc) issue_cnt_reg <= issue_cnt_reg + 32'd1;
            if (pop) out_cnt_reg   <= out_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg[0] <= acc;
            for (int i = 1; i < LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
            vfpu_lane_alu #(
                .LATENCY(LATENCY)
            ) u_alu (
                .clk_i  (clk_i),
                .a      (operand_data[gi*VFPU_LANE_WIDTH +: VFPU_LANE_WIDTH]),
                .b      (operand_data[DATA_WIDTH + gi*VFPU_LANE_WIDTH +: VFPU_LANE_WIDTH]),
                .op     (op_reg),
                .result (pipe_data[gi*VFPU_LANE_WIDTH +: VFPU_LANE_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_reg] <= pipe_data;
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)      fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
            else if (!push && pop) fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        end
    end

    assign busy_o = busy;
    assign done_o = done_reg;
    assign cnt_o  = out_cnt_reg;

endmodule

// File: tb/tb_vfpu_stream_engine.sv
// Directed bench for vfpu_stream_engine: opcode table, backpressure, skew, zero length,
// ignored restart and mid-job clear.
module tb_vfpu_stream_engine;
    import vfpu_package::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [31:0] len_i;
    logic [2:0]  op_i;
    logic [1:0]  operand_valid;
    logic [1:0]  operand_ready;
    logic [63:0] operand_data;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;
    logic [3:0]  result_strb;
    logic        busy_o;
    logic        done_o;
    logic [31:0] cnt_o;

    always #5 clk_i = ~clk_i;

    vfpu_stream_engine #(
        .DATA_WIDTH(32), .NB_OPERANDS(2), .LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .op_i(op_i), .operand_valid(operand_valid),
        .operand_ready(operand_ready), .operand_data(operand_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_strb(result_strb),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] va[32];
    logic [31:0] vb[32];
    logic [31:0] res_q[$];

    int hs_first, hs_stall, hs_bad, ready_split, ready_seen, busy_seen;
    int valid_first, done_cnt, done_k, last_res_k;

    // Drives one job cycle by cycle at the falling edge and observes the handshakes due next rising edge.
    task automatic run_job(input int n, input logic [2:0] op, input int stall, input int skew,
                           input int restart_at);
        int idx;
        idx = 0;
        hs_first = -1; hs_stall = 0; hs_bad = 0; ready_split = 0; ready_seen = 0;
        busy_seen = 0; valid_first = -1; done_cnt = 0; done_k = -1; last_res_k = -1;
        res_q.delete();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            start_i          = (k == 0) || (k == restart_at);
            len_i            = (k == 0) ? 32'(n) : 32'd5;
            op_i             = (k == 0) ? op : 3'd1;
            operand_valid[0] = (idx < n);
            operand_valid[1] = (idx < n) && (k >= skew);
            operand_data     = {vb[idx], va[idx]};
            result_ready     = (k >= stall);
            #1;
            if (busy_o) busy_seen++;
            if (|operand_ready) ready_seen++;
            if (operand_ready[0] != operand_ready[1]) ready_split++;
            if (operand_ready[0] && !(&operand_valid)) hs_bad++;
            if (operand_ready[0] && (&operand_valid)) begin
                if (hs_first < 0) hs_first = k;
                if (k < stall) hs_stall++;
                idx++;
            end
            if (result_valid && valid_first < 0) valid_first = k;
            if (result_valid && result_ready) begin
                res_q.push_back(result_data);
                last_res_k = k;
            end
            if (done_o) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        @(negedge clk_i);
        start_i = 1'b0; operand_valid = 2'b00; result_ready = 1'b1;
        if (done_k < 0) chk("job_timeout", 32'd0, 32'd1);
        $display("job n=%0d op=%0d results=%0d hs_first=%0d valid_first=%0d done_k=%0d cnt=%0d",
                 n, op, res_q.size(), hs_first, valid_first, done_k, cnt_o);
    endtask

    initial begin
        vecs[0]  = '{"add",      3'(ADD), 32'h00000005, 32'hFFFFFFFE, 32'h00000003};
        vecs[1]  = '{"sub_wrap", 3'(SUB), 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[2]  = '{"min_neg",  3'(MIN), 32'h80000000, 32'h00000001, 32'h80000000};
        vecs[3]  = '{"max_neg",  3'(MAX), 32'h80000000, 32'h00000001, 32'h00000001};
        vecs[4]  = '{"and",      3'(AND), 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vecs[5]  = '{"or",       3'(OR),  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
        vecs[6]  = '{"xor",      3'(XOR), 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00};
        vecs[7]  = '{"reserved", 3'd7,    32'h12345678, 32'h11111111, 32'h00000000};
        vecs[8]  = '{"add_wrap", 3'(ADD), 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[9]  = '{"min_pos",  3'(MIN), 32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFD};
        vecs[10] = '{"max_pos",  3'(MAX), 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        vecs[11] = '{"sub_neg",  3'(SUB), 32'h80000000, 32'h00000001, 32'h7FFFFFFF};

        for (int i = 0; i < 32; i++) begin
            va[i] = 32'd100 + 32'(i);
            vb[i] = 32'h1000 * 32'(i);
        end

        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0; op_i = '0;
        operand_valid = 2'b11; operand_data = '0; result_ready = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_ready", 32'(operand_ready), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cnt", cnt_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1; operand_valid = 2'b00;

        for (int v = 0; v < 12; v++) begin
            va[0] = vecs[v].a;
            vb[0] = vecs[v].b;
            run_job(1, vecs[v].op, 0, 0, -1);
            $display("vec %s a=0x%08h b=0x%08h got=0x%08h", vecs[v].name, vecs[v].a, vecs[v].b,
                     (res_q.size() > 0) ? res_q[0] : 32'hDEADBEEF);
            chk({vecs[v].name, "_count"}, 32'(res_q.size()), 32'd1);
            if (res_q.size() > 0) chk({vecs[v].name, "_data"}, res_q[0], vecs[v].exp);
            chk({vecs[v].name, "_hs"}, 32'(hs_first), 32'd1);
            chk({vecs[v].name, "_latency"}, 32'(valid_first - hs_first), 32'd3);
            chk({vecs[v].name, "_done_cnt"}, 32'(done_cnt), 32'd1);
            chk({vecs[v].name, "_cnt"}, cnt_o, 32'd1);
        end
        for (int i = 0; i < 32; i++) begin
            va[i] = 32'd100 + 32'(i);
            vb[i] = 32'h1000 * 32'(i);
        end

        // Backpressure: sink stalls for 20 cycles, only FIFO_DEPTH elements may be admitted.
        run_job(16, 3'(ADD), 20, 0, -1);
        chk("bp_accept_during_stall", 32'(hs_stall), 32'd4);
        chk("bp_count", 32'(res_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < res_q.size(); i++)
            chk($sformatf("bp_data%0d", i), res_q[i], va[i] + vb[i]);
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);
        chk("bp_done_after_last", 32'(done_k), 32'(last_res_k + 1));
        chk("bp_cnt", cnt_o, 32'd16);

        // Operand 1 valid lags operand 0 by three cycles.
        run_job(3, 3'(XOR), 0, 3, -1);
        chk("skew_first_hs", 32'(hs_first), 32'd3);
        chk("skew_bad_hs", 32'(hs_bad), 32'd0);
        chk("skew_split", 32'(ready_split), 32'd0);
        chk("skew_count", 32'(res_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < res_q.size(); i++)
            chk($sformatf("skew_data%0d", i), res_q[i], va[i] ^ vb[i]);

        // Zero-length job.
        run_job(0, 3'(ADD), 0, 0, -1);
        chk("len0_done_k", 32'(done_k), 32'd1);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);
        chk("len0_busy", 32'(busy_seen), 32'd0);
        chk("len0_ready", 32'(ready_seen), 32'd0);
        chk("len0_results", 32'(res_q.size()), 32'd0);

        // Start pulse while running must be ignored.
        run_job(4, 3'(ADD), 0, 0, 3);
        chk("restart_count", 32'(res_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < res_q.size(); i++)
            chk($sformatf("restart_data%0d", i), res_q[i], va[i] + vb[i]);
        chk("restart_done_cnt", 32'(done_cnt), 32'd1);
        chk("restart_cnt", cnt_o, 32'd4);

        // Clear with elements in the pipeline and FIFO.
        begin
            int cl_hs, cl_valid, cl_done;
            cl_hs = 0; cl_valid = 0; cl_done = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk_i);
                start_i = (k == 0); len_i = 32'd8; op_i = 3'(ADD);
                operand_valid = 2'b11; operand_data = {vb[k], va[k]}; result_ready = 1'b0;
                clear_i = (k == 4);
                #1;
                if (operand_ready[0]) cl_hs++;
                if (k == 4) begin
                    chk("clr_pre_valid", 32'(result_valid), 32'd1);
                    chk("clr_ready_gated", 32'(operand_ready), 32'd0);
                end
            end
            chk("clr_accepted", 32'(cl_hs), 32'd3);
            @(negedge clk_i);
            start_i = 1'b0; clear_i = 1'b0; operand_valid = 2'b00;
            #1;
            chk("clr_valid", 32'(result_valid), 32'd0);
            chk("clr_busy", 32'(busy_o), 32'd0);
            chk("clr_cnt", cnt_o, 32'd0);
            result_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_i);
                #1;
                if (result_valid) cl_valid++;
                if (done_o) cl_done++;
            end
            chk("clr_fifo_empty", 32'(cl_valid), 32'd0);
            chk("clr_no_done", 32'(cl_done), 32'd0);
            $display("clear test accepted=%0d late_valid=%0d late_done=%0d", cl_hs, cl_valid, cl_done);
        end

        va[0] = 32'h00000010; vb[0] = 32'h00000003;
        va[1] = 32'hFFFFFFF0; vb[1] = 32'h00000020;
        run_job(2, 3'(SUB), 0, 0, -1);
        chk("post_clr_count", 32'(res_q.size()), 32'd2);
        if (res_q.size() > 1) begin
            chk("post_clr_data0", res_q[0], 32'h0000000D);
            chk("post_clr_data1", res_q[1], 32'hFFFFFFD0);
        end
        chk("post_clr_done_cnt", 32'(done_cnt), 32'd1);
        chk("post_clr_cnt", cnt_o, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
